rom_prefetch: RTL and testbench

Instruction prefetch stage between the synchronous-read program ROM and the XMEGA core's decoder. It drives the ROM word address, absorbs the ROM's one-cycle read latency and buffers fetched 16-bit words in a small FIFO. Words are presented to the decoder over a valid/ready handshake. A jump request flushes the buffer and redirects fetch, so the core never sees stale words after a change of flow.

---
 rtl/rom_prefetch_pkg.sv | 13 +
 rtl/rom_prefetch_if.sv | 18 +
 rtl/rom_prefetch_fifo.sv | 41 ++++
 rtl/rom_prefetch.sv | 57 +++++
 tb/tb_rom_prefetch.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/rom_prefetch_pkg.sv
// rom_prefetch_pkg: shared widths and reset vector for the instruction prefetch stage
package rom_prefetch_pkg;
  localparam int RST_VECTOR_DEFAULT = 0;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int cnt_width(input int depth);
    return clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/rom_prefetch_if.sv
// rom_prefetch_if: ROM port and decoder handshake; ins_pc exists only with ROM_PREFETCH_PC_EN
interface rom_prefetch_if #(parameter int W = 14);
  logic [W-1:0] rom_a;
  logic [15:0]  rom_d;
  logic         jmp;
  logic [W-1:0] jmp_addr;
  logic         ins_valid;
  logic [15:0]  ins_data;
  logic         ins_ready;
`ifdef ROM_PREFETCH_PC_EN
  logic [W-1:0] ins_pc;
  modport master(input rom_d, jmp, jmp_addr, ins_ready, output rom_a, ins_valid, ins_data, ins_pc);
  modport slave(output rom_d, jmp, jmp_addr, ins_ready, input rom_a, ins_valid, ins_data, ins_pc);
`else
  modport master(input rom_d, jmp, jmp_addr, ins_ready, output rom_a, ins_valid, ins_data);
  modport slave(output rom_d, jmp, jmp_addr, ins_ready, input rom_a, ins_valid, ins_data);
`endif
endinterface

// File: rtl/rom_prefetch_fifo.sv
// prefetch_fifo: small power-of-two FIFO with flush taking priority over push and pop
module prefetch_fifo import rom_prefetch_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  logic                          i_flush,
  input  logic [WIDTH-1:0]              i_din,
  output logic [WIDTH-1:0]              o_head,
  output logic [cnt_width(DEPTH)-1:0]   o_count
);
  localparam int PW = clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd, r_wr;
  logic [CW-1:0]    r_count;
  assign o_count = r_count;
  assign o_head  = (r_count != '0) ? r_mem[r_rd] : '0;
  // storage array, written only on a push that is not cancelled by a flush
  always_ff @(posedge clk)
    if (i_push && !i_flush) r_mem[r_wr] <= i_din;
  // pointers and occupancy; a flush empties the buffer regardless of push/pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PW'(1);
      if (i_pop)  r_rd <= r_rd + PW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) (i_push && !i_flush) |-> (r_count != CW'(DEPTH)));
endmodule

// File: rtl/rom_prefetch.sv
// rom_prefetch: ROM fetch with credit-based issue, one-cycle latency absorption and jump flush (option: ROM_PREFETCH_PC_EN)
module rom_prefetch import rom_prefetch_pkg::*; #(
  parameter int ADDR_ROM_BUS_WIDTH = 14,
  parameter int DEPTH = 4,
  parameter logic [ADDR_ROM_BUS_WIDTH-1:0] RST_VECTOR = ADDR_ROM_BUS_WIDTH'(RST_VECTOR_DEFAULT)
) (
  input logic          clk,
  input logic          rst,
  rom_prefetch_if.master bus
);
  localparam int W  = ADDR_ROM_BUS_WIDTH;
  localparam int CW = cnt_width(DEPTH);
`ifdef ROM_PREFETCH_PC_EN
  localparam int FW = 16 + W;
`else
  localparam int FW = 16;
`endif
  logic [W-1:0]  r_fetch_pc, w_rom_a;
  logic          r_inflight, w_issue, w_push, w_pop, w_valid;
  logic [CW-1:0] w_count;
  logic [FW-1:0] w_din, w_head;
  // address select and credit check: a slot is reserved for every outstanding read
  always_comb begin
    w_rom_a = rst ? RST_VECTOR : bus.jmp ? bus.jmp_addr : r_fetch_pc;
    w_valid = w_count != '0;
    w_issue = bus.jmp || (({1'b0, w_count} + {{CW{1'b0}}, r_inflight}) < (CW+1)'(DEPTH));
    w_push  = r_inflight && !bus.jmp;
    w_pop   = w_valid && bus.ins_ready && !bus.jmp;
  end
  // fetch address and in-flight flag advance only when a read is issued
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_fetch_pc <= RST_VECTOR;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_fetch_pc <= w_rom_a + W'(1);
    end
`ifdef ROM_PREFETCH_PC_EN
  logic [W-1:0] r_inflight_pc;
  // remembers the address of the outstanding read so it travels with its word
  always_ff @(posedge clk or posedge rst)
    if (rst) r_inflight_pc <= '0;
    else if (w_issue) r_inflight_pc <= w_rom_a;
  assign w_din      = {r_inflight_pc, bus.rom_d};
  assign bus.ins_pc = w_head[FW-1:16];
`else
  assign w_din = bus.rom_d;
`endif
  prefetch_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .i_push(w_push), .i_pop(w_pop), .i_flush(bus.jmp),
    .i_din(w_din), .o_head(w_head), .o_count(w_count)
  );
  assign bus.rom_a     = w_rom_a;
  assign bus.ins_valid = w_valid;
  assign bus.ins_data  = w_head[15:0];
endmodule

// File: tb/tb_rom_prefetch.sv
// tb_rom_prefetch: scoreboard bench for rom_prefetch with a synchronous ROM model mem[i]=i+0x100
module tb_rom_prefetch;
  localparam int W = 14;
  localparam logic [W-1:0] RV = '0;
  typedef struct {logic [W-1:0] pc; logic [15:0] d;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  exp_t q[$];
  logic [W-1:0] nxt;
  int n_chk = 0, n_fail = 0, n_pop = 0;
  always #5 clk = ~clk;
  rom_prefetch_if #(.W(W)) bus();
  rom_prefetch #(.ADDR_ROM_BUS_WIDTH(W), .DEPTH(4), .RST_VECTOR(RV)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [15:0] rom(input logic [W-1:0] a);
    return 16'(a) + 16'h0100;
  endfunction
  always @(posedge clk) bus.rom_d <= rom(bus.rom_a);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic fill();
    while (q.size() < 8) begin
      q.push_back('{nxt, rom(nxt)});
      nxt = nxt + W'(1);
    end
  endtask
  task automatic restart(input logic [W-1:0] a);
    q.delete();
    nxt = a;
    fill();
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      fill();
    end
  endtask
  // monitor: every accepted word must be the next expected one
  always @(negedge clk)
    if (!rst && bus.ins_valid && bus.ins_ready && !bus.jmp) begin
      exp_t e;
      n_pop++;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: unexpected word %h", bus.ins_data);
      end else begin
        e = q.pop_front();
        chk("data", 32'(bus.ins_data), 32'(e.d));
`ifdef ROM_PREFETCH_PC_EN
        chk("pc", 32'(bus.ins_pc), 32'(e.pc));
`endif
      end
    end
  initial begin
    logic [W-1:0] a;
    bus.jmp = 1'b0;
    bus.jmp_addr = '0;
    bus.ins_ready = 1'b1;
    restart(RV);
    #1 rst = 1'b1;
    #11;
    chk("rst_valid", 32'(bus.ins_valid), 0);
    chk("rst_rom_a", 32'(bus.rom_a), 32'(RV));
    @(posedge clk);
    #2 rst = 1'b0;
    cyc();
    chk("e1_valid", 32'(bus.ins_valid), 0);
    chk("e1_rom_a", 32'(bus.rom_a), 32'(RV) + 1);
    cyc();
    chk("e2_valid", 32'(bus.ins_valid), 1);
    chk("e2_data", 32'(bus.ins_data), 32'h0100);
    cyc(6);
    bus.ins_ready = 1'b0;
    cyc(10);
    chk("stall_valid", 32'(bus.ins_valid), 1);
    chk("stall_head", 32'(bus.ins_data), 32'(q[0].d));
    chk("stall_rom_a", 32'(bus.rom_a), 32'(q[0].pc + W'(4)));
    bus.ins_ready = 1'b1;
    cyc(8);
    bus.ins_ready = 1'b0;
    cyc(6);
    chk("full_valid", 32'(bus.ins_valid), 1);
    bus.ins_ready = 1'b1;
    bus.jmp = 1'b1;
    bus.jmp_addr = W'(16'h0200);
    restart(W'(16'h0200));
    #1 chk("jmp_rom_a", 32'(bus.rom_a), 32'h0200);
    cyc();
    bus.jmp = 1'b0;
    #1 chk("jmp_gap_valid", 32'(bus.ins_valid), 0);
    cyc();
    chk("jmp_valid", 32'(bus.ins_valid), 1);
    chk("jmp_data", 32'(bus.ins_data), 32'h0300);
    cyc(6);
    bus.jmp = 1'b1;
    bus.jmp_addr = W'(16'h3FFE);
    restart(W'(16'h3FFE));
    cyc();
    bus.jmp = 1'b0;
    #1 chk("wrap_rom_a0", 32'(bus.rom_a), 32'h3FFF);
    cyc();
    chk("wrap_rom_a1", 32'(bus.rom_a), 32'h0000);
    chk("wrap_data0", 32'(bus.ins_data), 32'h40FE);
    cyc();
    chk("wrap_rom_a2", 32'(bus.rom_a), 32'h0001);
    chk("wrap_data1", 32'(bus.ins_data), 32'h40FF);
    cyc(6);
    #2 rst = 1'b1;
    bus.jmp = 1'b1;
    bus.jmp_addr = W'(16'h0123);
    #1;
    chk("arst_valid", 32'(bus.ins_valid), 0);
    chk("arst_rom_a", 32'(bus.rom_a), 32'(RV));
    chk("arst_data", 32'(bus.ins_data), 0);
    bus.jmp = 1'b0;
    restart(RV);
    @(posedge clk);
    #2 rst = 1'b0;
    cyc();
    chk("arst_e1_valid", 32'(bus.ins_valid), 0);
    cyc();
    chk("arst_e2_valid", 32'(bus.ins_valid), 1);
    chk("arst_e2_data", 32'(bus.ins_data), 32'h0100);
    n_pop = 0;
    repeat (10000) begin
      bus.ins_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 49) == 0) begin
        a = W'($urandom);
        bus.jmp = 1'b1;
        bus.jmp_addr = a;
        restart(a);
      end else bus.jmp = 1'b0;
      cyc();
    end
    bus.jmp = 1'b0;
    bus.ins_ready = 1'b1;
    cyc(10);
    chk("random_progress", 32'(n_pop > 5000), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
